mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multicycle CPU memory interface (port C) and the program/debug loader (port L).
- Each request is latched, issued to memory as one single-cycle access, and the memory's fixed read latency is counted out.
- The read data is returned to the owning port with a one-cycle acknowledge.
- Round-robin arbitration; memory latency set by parameter.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, cycles from the issue cycle until mem_rdata is valid (legal 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-low reset
c_req  in  1  CPU request, held until c_ack
c_we  in  1  CPU write enable (1 = write)
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_ack  out  1  CPU acknowledge, one-cycle pulse
c_rdata  out  DW  CPU read data, registered
l_req  in  1  loader request, held until l_ack
l_we  in  1  loader write enable
l_addr  in  AW  loader address
l_wdata  in  DW  loader write data
l_ack  out  1  loader acknowledge, one-cycle pulse
l_rdata  out  DW  loader read data, registered
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high whenever state != IDLE
owner  out  1  0 = CPU, 1 = loader; meaningful while busy

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = IDLE.
  - All outputs 0: c_rdata/l_rdata = 0, mem_addr/mem_wdata = 0, owner = 0.
  - last_grant = 1, so the CPU wins the first tie.
  - Latency counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port != last_grant.
  - On grant: latch we/addr/wdata into mem_we/mem_addr/mem_wdata registers; owner <= winner; last_grant <= winner; go to ISSUE.
- ISSUE:
  - mem_en = 1 for exactly this cycle.
  - cnt <= MEM_LAT-1; go to WAIT.
- WAIT:
  - If cnt == 0: capture mem_rdata into the owner's rdata register (reads only; writes leave both rdata registers unchanged) and go to RESP.
  - Otherwise: decrement cnt and stay.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP:
  - Assert owner's ack for one cycle; the other ack stays 0; go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle t0 → mem_en at t0+1 → mem_rdata sampled at t0+1+MEM_LAT → ack at t0+MEM_LAT+2.
  - Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Handshake:
  - A requester drops req on the edge where it samples ack = 1.
  - req still high in the cycle after ack counts as a new request.
  - Inputs are latched at grant; changes afterwards are ignored.
  - req withdrawn before ack is illegal; the access still completes and ack is still pulsed.
- Fairness: with both requests held continuously, grants strictly alternate C, L, C, L.
- Outputs between accesses:
  - mem_en, c_ack, l_ack are 0 outside ISSUE/RESP.
  - mem_addr/mem_we/mem_wdata hold their last latched values.
  - rdata registers hold their value until the next read by the same port.
- Reset mid-operation (any state):
  - Next state is IDLE; no ack is issued; mem_en is 0.
  - A write already strobed in ISSUE is not undone.
- MEM_LAT outside 1..15: unsupported, no checking required.

Test Plan:
- Reset: reset = 0 for 2 cycles with both reqs high → all outputs 0, busy 0, no mem_en; after release, CPU is granted first.
- CPU read, MEM_LAT = 1: c_req at t0, c_addr 0x10; model returns 0xDEADBEEF at t0+2 only → mem_en=1/mem_we=0/mem_addr=0x10 at t0+1; c_ack=1 with c_rdata=0xDEADBEEF at t0+3; l_ack never asserts.
- Contention: c_req and l_req held high continuously for 4 accesses → mem_en owners C, L, C, L; acks at cycles 3, 7, 11, 15 after release; owner/busy match.
- Loader write: l_we=1, l_addr 0x20, l_wdata 0x12345678 → single mem_en pulse with mem_we=1/addr 0x20/wdata 0x12345678; l_ack pulses; c_rdata and l_rdata unchanged.
- MEM_LAT = 3: CPU read at t0, bench drives 0xA5A5A5A5 at t0+4 and garbage elsewhere → c_ack at t0+5 with c_rdata 0xA5A5A5A5; busy high t0+1..t0+5.
- Reset during WAIT (MEM_LAT = 3) → no c_ack; busy = 0 the next cycle; a following loader read completes normally with correct l_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU (C) and the
// loader (L); each grant is one strobed access with a fixed read latency.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] l_rdata_q, l_rdata_d;
    logic          grant_l;

    // Loader wins when alone, or on a tie when the CPU had the last grant.
    assign grant_l = l_req & (~c_req | ~last_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (c_req || l_req) begin
                    owner_d = grant_l;
                    last_d  = grant_l;
                    we_d    = grant_l ? l_we    : c_we;
                    addr_d  = grant_l ? l_addr  : c_addr;
                    wdata_d = grant_l ? l_wdata : c_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            l_rdata_d = mem_rdata;
                        end else begin
                            c_rdata_d = mem_rdata;
                        end
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign c_ack     = (state_q == RESP) & ~owner_q;
    assign l_ack     = (state_q == RESP) & owner_q;
    assign c_rdata   = c_rdata_q;
    assign l_rdata   = l_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A runs MEM_LAT=1,
// instance B runs MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic        a_rst, a_c_req, a_c_we, a_l_req, a_l_we;
    logic [31:0] a_c_addr, a_c_wdata, a_l_addr, a_l_wdata, a_mem_rdata;
    logic        a_c_ack, a_l_ack, a_mem_en, a_mem_we, a_busy, a_owner;
    logic [31:0] a_c_rdata, a_l_rdata, a_mem_addr, a_mem_wdata;

    logic        b_rst, b_c_req, b_c_we, b_l_req, b_l_we;
    logic [31:0] b_c_addr, b_c_wdata, b_l_addr, b_l_wdata, b_mem_rdata;
    logic        b_c_ack, b_l_ack, b_mem_en, b_mem_we, b_busy, b_owner;
    logic [31:0] b_c_rdata, b_l_rdata, b_mem_addr, b_mem_wdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(a_rst),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr),
        .c_wdata(a_c_wdata), .c_ack(a_c_ack), .c_rdata(a_c_rdata),
        .l_req(a_l_req), .l_we(a_l_we), .l_addr(a_l_addr),
        .l_wdata(a_l_wdata), .l_ack(a_l_ack), .l_rdata(a_l_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(b_rst),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr),
        .c_wdata(b_c_wdata), .c_ack(b_c_ack), .c_rdata(b_c_rdata),
        .l_req(b_l_req), .l_we(b_l_we), .l_addr(b_l_addr),
        .l_wdata(b_l_wdata), .l_ack(b_l_ack), .l_rdata(b_l_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b0;
        a_c_req = 1'b1; a_l_req = 1'b1;
        a_c_we = 1'b0; a_l_we = 1'b1;
        a_c_addr = 32'h10; a_l_addr = 32'h20;
        a_c_wdata = 32'h1; a_l_wdata = 32'h2;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({a_mem_en, a_busy, a_c_ack, a_l_ack, a_owner, a_mem_we} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc%0d: got %b required 000000", i,
                         {a_mem_en, a_busy, a_c_ack, a_l_ack, a_owner, a_mem_we});
            end
            vectors++;
            if ({a_c_rdata, a_l_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin
                errors++;
                $display("FAIL reset_data cyc%0d: got %h required 0", i,
                         {a_c_rdata, a_l_rdata, a_mem_addr, a_mem_wdata});
            end
        end
        a_rst = 1'b1;
        step();
        vectors++;
        if (a_mem_en !== 1'b1 || a_owner !== 1'b0 || a_mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL reset_first_grant: got en=%b own=%b addr=%h required en=1 own=0 addr=10",
                     a_mem_en, a_owner, a_mem_addr);
        end
        a_c_req = 1'b0; a_l_req = 1'b0;
        step();
        step();
        vectors++;
        if (a_c_ack !== 1'b1 || a_l_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_ack: got c=%b l=%b required c=1 l=0", a_c_ack, a_l_ack);
        end
        step();
        vectors++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_idle: got busy=%b required 0", a_busy);
        end
    endtask

    task automatic test_cpu_read();
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h10;
        a_mem_rdata = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            a_mem_rdata = (k == 2) ? 32'hDEADBEEF : 32'h1111_1111;
            vectors++;
            if (a_l_ack !== 1'b0) begin
                errors++;
                $display("FAIL cpu_read_lack t0+%0d: got %b required 0", k, a_l_ack);
            end
            if (k == 1) begin
                vectors++;
                if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL cpu_read_issue: got en=%b we=%b addr=%h required 1 0 10",
                             a_mem_en, a_mem_we, a_mem_addr);
                end
            end
            if (k == 3) begin
                vectors++;
                if (a_c_ack !== 1'b1 || a_c_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL cpu_read_ack: got ack=%b rdata=%h required 1 deadbeef",
                             a_c_ack, a_c_rdata);
                end
                a_c_req = 1'b0;
            end
            if (k == 4) begin
                vectors++;
                if (a_c_ack !== 1'b0 || a_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL cpu_read_after: got ack=%b busy=%b required 0 0", a_c_ack, a_busy);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic       exp_own;
        int         ph;
        a_rst = 1'b0;
        step();
        a_rst = 1'b1;
        a_c_req = 1'b1; a_l_req = 1'b1;
        a_c_we = 1'b0; a_l_we = 1'b0;
        a_c_addr = 32'h100; a_l_addr = 32'h200;
        for (int k = 0; k < 16; k++) begin
            a_mem_rdata = 32'hC0DE0000 + 32'(k);
            ph = k % 4;
            exp_own = ((k / 4) % 2) == 1;
            vectors++;
            if (a_mem_en !== (ph == 1) || a_busy !== (ph != 0)) begin
                errors++;
                $display("FAIL contention_en_busy cyc%0d: got en=%b busy=%b required %b %b",
                         k, a_mem_en, a_busy, ph == 1, ph != 0);
            end
            vectors++;
            if (a_c_ack !== (ph == 3 && !exp_own) || a_l_ack !== (ph == 3 && exp_own)) begin
                errors++;
                $display("FAIL contention_ack cyc%0d: got c=%b l=%b required %b %b",
                         k, a_c_ack, a_l_ack, ph == 3 && !exp_own, ph == 3 && exp_own);
            end
            if (ph != 0) begin
                vectors++;
                if (a_owner !== exp_own) begin
                    errors++;
                    $display("FAIL contention_owner cyc%0d: got %b required %b", k, a_owner, exp_own);
                end
            end
            if (ph == 1) begin
                vectors++;
                if (a_mem_addr !== (exp_own ? 32'h200 : 32'h100)) begin
                    errors++;
                    $display("FAIL contention_addr cyc%0d: got %h required %h", k, a_mem_addr,
                             exp_own ? 32'h200 : 32'h100);
                end
            end
            if (ph == 3) begin
                vectors++;
                if ((exp_own ? a_l_rdata : a_c_rdata) !== 32'hC0DE0000 + 32'(k - 1)) begin
                    errors++;
                    $display("FAIL contention_rdata cyc%0d: got %h required %h", k,
                             exp_own ? a_l_rdata : a_c_rdata, 32'hC0DE0000 + 32'(k - 1));
                end
                if (k == 15) begin
                    a_c_req = 1'b0; a_l_req = 1'b0;
                end
            end
            step();
        end
        vectors++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_end: got busy=%b required 0", a_busy);
        end
    endtask

    task automatic test_loader_write();
        logic [31:0] cr, lr;
        int          en_cnt;
        cr = a_c_rdata;
        lr = a_l_rdata;
        en_cnt = 0;
        a_mem_rdata = 32'hFFFF_FFFF;
        a_l_req = 1'b1; a_l_we = 1'b1;
        a_l_addr = 32'h20; a_l_wdata = 32'h12345678;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (a_mem_en) en_cnt++;
            if (k == 1) begin
                vectors++;
                if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h20 || a_mem_wdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL loader_write_issue: got we=%b addr=%h wdata=%h required 1 20 12345678",
                             a_mem_we, a_mem_addr, a_mem_wdata);
                end
            end
            if (k == 3) begin
                vectors++;
                if (a_l_ack !== 1'b1 || a_c_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL loader_write_ack: got l=%b c=%b required 1 0", a_l_ack, a_c_ack);
                end
                a_l_req = 1'b0;
            end
        end
        vectors++;
        if (en_cnt != 1) begin
            errors++;
            $display("FAIL loader_write_pulses: got %0d required 1", en_cnt);
        end
        vectors++;
        if (a_c_rdata !== cr || a_l_rdata !== lr) begin
            errors++;
            $display("FAIL loader_write_rdata: got c=%h l=%h required c=%h l=%h",
                     a_c_rdata, a_l_rdata, cr, lr);
        end
        vectors++;
        if (a_mem_addr !== 32'h20 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL loader_write_hold: got addr=%h busy=%b required 20 0", a_mem_addr, a_busy);
        end
    endtask

    task automatic test_lat3();
        step();
        b_rst = 1'b1;
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'h30;
        b_mem_rdata = 32'h0BAD0000;
        for (int k = 1; k <= 6; k++) begin
            step();
            b_mem_rdata = (k == 4) ? 32'hA5A5A5A5 : 32'h0BAD0000 + 32'(k);
            vectors++;
            if (b_busy !== (k <= 5) || b_mem_en !== (k == 1)) begin
                errors++;
                $display("FAIL lat3_busy_en t0+%0d: got busy=%b en=%b required %b %b",
                         k, b_busy, b_mem_en, k <= 5, k == 1);
            end
            vectors++;
            if (b_c_ack !== (k == 5) || b_l_ack !== 1'b0) begin
                errors++;
                $display("FAIL lat3_ack t0+%0d: got c=%b l=%b required %b 0", k, b_c_ack, b_l_ack, k == 5);
            end
            if (k == 5) begin
                vectors++;
                if (b_c_rdata !== 32'hA5A5A5A5) begin
                    errors++;
                    $display("FAIL lat3_rdata: got %h required a5a5a5a5", b_c_rdata);
                end
                b_c_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_in_wait();
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'h40;
        b_mem_rdata = 32'h7777_7777;
        step();
        vectors++;
        if (b_mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_issue: got en=%b required 1", b_mem_en);
        end
        step();
        b_rst = 1'b0;
        step();
        vectors++;
        if (b_busy !== 1'b0 || b_c_ack !== 1'b0 || b_mem_en !== 1'b0 || b_c_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstwait_after: got busy=%b ack=%b en=%b rdata=%h required 0 0 0 0",
                     b_busy, b_c_ack, b_mem_en, b_c_rdata);
        end
        b_rst = 1'b1;
        b_c_req = 1'b0;
        step();
        vectors++;
        if (b_busy !== 1'b0 || b_c_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_idle: got busy=%b ack=%b required 0 0", b_busy, b_c_ack);
        end
        b_l_req = 1'b1; b_l_we = 1'b0; b_l_addr = 32'h44;
        for (int k = 1; k <= 6; k++) begin
            step();
            b_mem_rdata = (k == 4) ? 32'h5A5A1234 : 32'hEEEE0000 + 32'(k);
            vectors++;
            if (b_l_ack !== (k == 5) || b_c_ack !== 1'b0) begin
                errors++;
                $display("FAIL rstwait_lread_ack t0+%0d: got l=%b c=%b required %b 0",
                         k, b_l_ack, b_c_ack, k == 5);
            end
            if (k == 1) begin
                vectors++;
                if (b_mem_addr !== 32'h44 || b_owner !== 1'b1) begin
                    errors++;
                    $display("FAIL rstwait_lread_issue: got addr=%h own=%b required 44 1",
                             b_mem_addr, b_owner);
                end
            end
            if (k == 5) begin
                vectors++;
                if (b_l_rdata !== 32'h5A5A1234 || b_c_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL rstwait_lread_rdata: got l=%h c=%h required 5a5a1234 0",
                             b_l_rdata, b_c_rdata);
                end
                b_l_req = 1'b0;
            end
        end
    endtask

    initial begin
        a_rst = 1'b0; a_c_req = 1'b0; a_c_we = 1'b0; a_l_req = 1'b0; a_l_we = 1'b0;
        a_c_addr = '0; a_c_wdata = '0; a_l_addr = '0; a_l_wdata = '0; a_mem_rdata = '0;
        b_rst = 1'b0; b_c_req = 1'b0; b_c_we = 1'b0; b_l_req = 1'b0; b_l_we = 1'b0;
        b_c_addr = '0; b_c_wdata = '0; b_l_addr = '0; b_l_wdata = '0; b_mem_rdata = '0;
        #1;
        test_reset();
        test_cpu_read();
        test_contention();
        test_loader_write();
        test_lat3();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
